// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array job scheduler.
package sa_pkg;
  localparam int N     = 4;
  localparam int K     = 8;
  localparam int LAT   = K + 2*N - 2;
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAL    = 2'd1,
    RETIRE = 2'd2
  } state_t;

  function automatic int psumIdx(input int r, input int c);
    return r*N + c;
  endfunction
endpackage

// File: rtl/sa_job_sched_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves to the loser of the job just retired.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstSys,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic [1:0] i_won,
  output logic [1:0] o_gnt
);
  logic r_ptr;

  always_ff @(posedge clk or posedge rstSys) begin
    if (rstSys)     r_ptr <= 1'b0;
    else if (i_upd) r_ptr <= i_won[0];
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[0] && (!i_req[1] || !r_ptr)) o_gnt = 2'b01;
    else if (i_req[1])                     o_gnt = 2'b10;
  end
endmodule

// File: rtl/sa_job_sched.sv
// Job scheduler/sequencer for the NxN systolic PE array: arbitrates two requesters
// and walks one job through CAL/RETIRE, decoding all array controls from state/latCnt.
module sa_job_sched
  import sa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstSys,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] reqAddr0,
  input  logic [ADDR_W-1:0] reqAddr1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              busy,
  output logic              rstnPipe,
  output logic [N*N-1:0]    rstnPsum,
  output logic [LAT_W-1:0]  latCnt,
  output logic              opEn,
  output logic [ADDR_W-1:0] opAddr,
  output logic [N*N-1:0]    resValid
);
  state_t            r_state, w_state_nx;
  logic [LAT_W-1:0]  r_lat, w_lat_nx;
  logic [1:0]        r_grant, w_grant_nx, w_win;
  logic [ADDR_W-1:0] r_base, w_base_nx;
  logic              w_cal, w_ret, w_op_en;

  assign w_cal = (r_state == CAL);
  assign w_ret = (r_state == RETIRE);

  rr_arb2 u_arb (
    .clk    (clk),
    .rstSys (rstSys),
    .i_req  (req),
    .i_upd  (w_ret),
    .i_won  (r_grant),
    .o_gnt  (w_win)
  );

  always_ff @(posedge clk or posedge rstSys) begin
    if (rstSys) begin
      r_state <= IDLE;
      r_lat   <= '0;
      r_grant <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_lat   <= w_lat_nx;
      r_grant <= w_grant_nx;
      r_base  <= w_base_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_lat_nx   = r_lat;
    w_grant_nx = r_grant;
    w_base_nx  = r_base;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_state_nx = CAL;
          w_lat_nx   = '0;
          w_grant_nx = w_win;
          w_base_nx  = w_win[1] ? reqAddr1 : reqAddr0;
        end
      end
      CAL: begin
        if (r_lat == LAT_W'(LAT)) begin
          w_state_nx = RETIRE;
          w_lat_nx   = '0;
        end else begin
          w_lat_nx = r_lat + LAT_W'(1);
        end
      end
      RETIRE: begin
        w_state_nx = IDLE;
        w_grant_nx = '0;
      end
      default: begin
        w_state_nx = IDLE;
        w_lat_nx   = '0;
        w_grant_nx = '0;
      end
    endcase
  end

  // Everything below decodes registered state only, so req never reaches an output.
  assign w_op_en  = w_cal && (r_lat <= LAT_W'(K + N - 2));
  assign grant    = r_grant;
  assign done     = w_ret ? r_grant : 2'b00;
  assign busy     = w_cal || w_ret;
  assign rstnPipe = w_cal;
  assign rstnPsum = {(N*N){w_cal && (r_lat != '0)}};
  assign latCnt   = r_lat;
  assign opEn     = w_op_en;
  assign opAddr   = w_op_en ? (r_base + ADDR_W'(r_lat)) : '0;

  // PE(r,c) finishes once its skewed operand stream has fully passed: latCnt == K+r+c.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign resValid[psumIdx(r, c)] = w_cal && (r_lat == LAT_W'(K + r + c));
    end
  end
endmodule

// File: tb/tb_sa_job_sched.sv
// Randomized and directed bench for sa_job_sched against a job-position reference model.
module tb_sa_job_sched;
  import sa_pkg::*;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstSys;
  logic [1:0]    req;
  logic [AW-1:0] reqAddr0, reqAddr1;
  logic [1:0]    grant, done;
  logic          busy, rstnPipe, opEn;
  logic [15:0]   rstnPsum, resValid;
  logic [3:0]    latCnt;
  logic [AW-1:0] opAddr;
  logic [50:0]   act;

  int checks = 0;
  int errors = 0;

  // Model: m_pos = -1 idle, 0..LAT computing, LAT+1 retiring.
  int m_pos, m_owner, m_ptr, m_base;

  sa_job_sched #(.ADDR_W(AW)) dut (
    .clk(clk), .rstSys(rstSys), .req(req), .reqAddr0(reqAddr0), .reqAddr1(reqAddr1),
    .grant(grant), .done(done), .busy(busy), .rstnPipe(rstnPipe), .rstnPsum(rstnPsum),
    .latCnt(latCnt), .opEn(opEn), .opAddr(opAddr), .resValid(resValid)
  );

  always #5 clk = ~clk;

  assign act = {grant, done, busy, rstnPipe, rstnPsum, latCnt, opEn, opAddr, resValid};

  function automatic int mwin(input logic [1:0] r, input int p);
    if (r == 2'b11) return p;
    return r[1] ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rstSys) begin
    if (rstSys) begin
      m_pos <= -1; m_owner <= 0; m_ptr <= 0; m_base <= 0;
    end else if (m_pos < 0) begin
      if (req != 2'b00) begin
        m_owner <= mwin(req, m_ptr);
        m_base  <= (mwin(req, m_ptr) == 1) ? int'(reqAddr1) : int'(reqAddr0);
        m_pos   <= 0;
      end
    end else if (m_pos <= LAT) begin
      m_pos <= m_pos + 1;
    end else begin
      m_pos <= -1;
      m_ptr <= 1 - m_owner;
    end
  end

  function automatic logic [50:0] exp_vec();
    logic [1:0] g, d; logic cal, ret, oe; logic [15:0] rv; logic [7:0] oa; logic [3:0] lc;
    cal = (m_pos >= 0) && (m_pos <= LAT);
    ret = (m_pos == LAT + 1);
    g   = (cal || ret) ? 2'(1 << m_owner) : 2'b00;
    d   = ret ? g : 2'b00;
    oe  = cal && (m_pos <= K + N - 2);
    oa  = oe ? 8'((m_base + m_pos) % 256) : 8'h00;
    lc  = cal ? 4'(m_pos) : 4'h0;
    rv  = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (cal && m_pos == K + r + c) rv[r*N + c] = 1'b1;
    return {g, d, cal || ret, cal, {16{cal && m_pos != 0}}, lc, oe, oa, rv};
  endfunction

  task automatic do_reset();
    @(negedge clk); rstSys = 1'b1; req = 2'b00;
    @(negedge clk); rstSys = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rstSys = 1'b1; req = 2'b11; reqAddr0 = 8'h11; reqAddr1 = 8'h22;
    repeat (3) begin
      @(negedge clk);
      checks++; if (act !== '0) begin errors++; $display("FAIL reset_outputs act=%h exp=0", act); end
    end
    rstSys = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL reset_first_grant got=%b exp=01", grant); end
    req = 2'b00;
    repeat (LAT + 3) begin
      @(negedge clk);
      checks++; if (act !== exp_vec()) begin errors++; $display("FAIL reset_job act=%h exp=%h", act, exp_vec()); end
    end
  endtask

  task automatic test_single_job();
    int g_cnt, oe_cnt, done_cnt, psum0_cnt, b0, b5, b15;
    logic [7:0] first_a, last_a;
    g_cnt = 0; oe_cnt = 0; done_cnt = 0; psum0_cnt = 0; b0 = -1; b5 = -1; b15 = -1;
    first_a = 8'h00; last_a = 8'h00;
    do_reset();
    reqAddr1 = 8'h40; req = 2'b10;
    repeat (20) begin
      @(negedge clk);
      checks++; if (act !== exp_vec()) begin errors++; $display("FAIL single_vec act=%h exp=%h", act, exp_vec()); end
      if (grant == 2'b10) begin g_cnt++; req = 2'b00; end
      if (opEn) begin if (oe_cnt == 0) first_a = opAddr; last_a = opAddr; oe_cnt++; end
      if (rstnPipe && rstnPsum == '0) psum0_cnt++;
      if (done == 2'b10 && latCnt == 4'd0) done_cnt++;
      if (resValid[0])  b0  = int'(latCnt);
      if (resValid[5])  b5  = int'(latCnt);
      if (resValid[15]) b15 = int'(latCnt);
    end
    checks++; if (g_cnt != 16) begin errors++; $display("FAIL single_grant_len got=%0d exp=16", g_cnt); end
    checks++; if (oe_cnt != 11) begin errors++; $display("FAIL single_open_len got=%0d exp=11", oe_cnt); end
    checks++; if (first_a !== 8'h40 || last_a !== 8'h4A) begin errors++; $display("FAIL single_opaddr got=%h..%h exp=40..4a", first_a, last_a); end
    checks++; if (psum0_cnt != 1) begin errors++; $display("FAIL single_psum_clr got=%0d exp=1", psum0_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done got=%0d exp=1", done_cnt); end
    checks++; if (b0 != 8 || b5 != 10 || b15 != 14) begin errors++; $display("FAIL single_resvalid got=%0d,%0d,%0d exp=8,10,14", b0, b5, b15); end
  endtask

  task automatic test_contention();
    int rise_t[$]; logic [1:0] rise_v[$]; logic [1:0] done_v[$]; logic [1:0] prev_g;
    do_reset();
    prev_g = 2'b00; req = 2'b11;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      checks++; if (act !== exp_vec()) begin errors++; $display("FAIL contend_vec act=%h exp=%h", act, exp_vec()); end
      if (prev_g == 2'b00 && grant != 2'b00) begin rise_t.push_back(cyc); rise_v.push_back(grant); end
      if (done != 2'b00) done_v.push_back(done);
      prev_g = grant;
    end
    req = 2'b00;
    checks++;
    if (rise_v.size() != 3 || done_v.size() != 2) begin
      errors++; $display("FAIL contend_count rises=%0d dones=%0d exp=3,2", rise_v.size(), done_v.size());
    end else begin
      checks++; if (rise_v[0] !== 2'b01 || rise_v[1] !== 2'b10 || rise_v[2] !== 2'b01) begin
        errors++; $display("FAIL contend_order got=%b,%b,%b exp=01,10,01", rise_v[0], rise_v[1], rise_v[2]); end
      checks++; if (rise_t[1] - rise_t[0] != 17 || rise_t[2] - rise_t[1] != 17) begin
        errors++; $display("FAIL contend_spacing got=%0d,%0d exp=17,17", rise_t[1] - rise_t[0], rise_t[2] - rise_t[1]); end
      checks++; if (done_v[0] !== rise_v[0] || done_v[1] !== rise_v[1]) begin
        errors++; $display("FAIL contend_done got=%b,%b exp=%b,%b", done_v[0], done_v[1], rise_v[0], rise_v[1]); end
    end
  endtask

  task automatic test_abandon();
    int done_cnt, rise_cnt; logic [1:0] prev_g;
    done_cnt = 0; rise_cnt = 0; prev_g = 2'b00;
    do_reset();
    reqAddr0 = 8'($urandom); req = 2'b01;
    repeat (25) begin
      @(negedge clk);
      checks++; if (act !== exp_vec()) begin errors++; $display("FAIL abandon_vec act=%h exp=%h", act, exp_vec()); end
      if (grant == 2'b01 && latCnt == 4'd3) req = 2'b00;
      if (done == 2'b01) done_cnt++;
      if (prev_g == 2'b00 && grant != 2'b00) rise_cnt++;
      prev_g = grant;
    end
    checks++; if (done_cnt != 1 || rise_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL abandon_result dones=%0d grants=%0d busy=%b exp=1,1,0", done_cnt, rise_cnt, busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] seen[$];
    logic [7:0] wexp [11] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_reset();
    reqAddr0 = 8'hFC; req = 2'b01;
    repeat (20) begin
      @(negedge clk);
      if (grant != 2'b00) req = 2'b00;
      if (opEn) seen.push_back(opAddr);
    end
    checks++;
    if (seen.size() != 11) begin errors++; $display("FAIL wrap_len got=%0d exp=11", seen.size()); end
    else for (int i = 0; i < 11; i++) begin
      checks++; if (seen[i] !== wexp[i]) begin errors++; $display("FAIL wrap_addr idx=%0d got=%h exp=%h", i, seen[i], wexp[i]); end
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    reqAddr1 = 8'($urandom); req = 2'b10;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (grant != 2'b00) req = 2'b00;
    end while (!(grant == 2'b10 && latCnt == 4'd9) && n < 30);
    checks++; if (n >= 30) begin errors++; $display("FAIL async_wait_lat9 timeout latCnt=%0d", latCnt); end
    #1 rstSys = 1'b1;
    #1;
    checks++; if (act !== '0) begin errors++; $display("FAIL async_clear act=%h exp=0", act); end
    @(negedge clk);
    checks++; if (act !== '0) begin errors++; $display("FAIL async_held act=%h exp=0", act); end
    rstSys = 1'b0; reqAddr0 = 8'($urandom); req = 2'b01;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || latCnt !== 4'd0) begin
      errors++; $display("FAIL async_restart grant=%b lat=%0d exp=01,0", grant, latCnt); end
    req = 2'b00;
    repeat (18) begin
      @(negedge clk);
      checks++; if (act !== exp_vec()) begin errors++; $display("FAIL async_job act=%h exp=%h", act, exp_vec()); end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (600) begin
      @(negedge clk);
      checks++; if (act !== exp_vec()) begin errors++; $display("FAIL random_vec pos=%0d act=%h exp=%h", m_pos, act, exp_vec()); end
      for (int i = 0; i < 2; i++) begin
        if (m_pos == LAT + 1 && m_owner == i) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && m_pos >= 0 && m_owner == i && $urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
      reqAddr0 = 8'($urandom);
      reqAddr1 = 8'($urandom);
    end
  endtask

  initial begin
    rstSys = 1'b1; req = 2'b00; reqAddr0 = '0; reqAddr1 = '0;
    test_reset();
    test_single_job();
    test_contention();
    test_abandon();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
